// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add the fetch_count performance counter port and register.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
`ifdef FETCH_PERF_CNT_EN
    output logic        if_id_valid,
    output logic [31:0] fetch_count
`else
    output logic        if_id_valid
`endif
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        if_id_load;

    assign imem_addr  = pc;
    assign pc_plus4   = pc + 32'd4;
    assign if_id_load = !flush && !stall;

    // A redirect overrides a stall; the low two target bits are masked off.
    always_comb begin
        pc_next = pc;
        if (pc_src) begin
            pc_next = branch_target & ~32'h00000003;
        end else if (!stall) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_instr <= '0;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= imem_instr;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (if_id_load) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    logic unused_load;
    assign unused_load = if_id_load;
`endif

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port imem_addr  output  32  fetch address driven to the instruction memory, which uses word index addr[15:2].
REQ-005 SHALL provide port imem_instr  input  32  combinational instruction read back for imem_addr in the same cycle.
REQ-006 SHALL provide port stall  input  1  hazard hold: freeze the PC and the IF/ID register.
REQ-007 SHALL provide port flush  input  1  insert a bubble into the IF/ID register.
REQ-008 SHALL provide port pc_src  input  1  redirect: take branch_target as the next PC.
REQ-009 SHALL provide port branch_target  input  32  redirect address from the ID stage.
REQ-010 SHALL provide port if_id_instr  output  32  registered instruction to the decode stage.
REQ-011 SHALL provide port if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-012 SHALL provide port if_id_valid  output  1  1 when if_id_instr is a real fetched instruction, 0 for a bubble.
REQ-013 SHALL provide port fetch_count  output  32  number of valid IF/ID loads; present only per REQ-027.

Function
REQ-014 SHALL drive imem_addr combinationally from the PC register, with no added latency.
REQ-015 SHALL compute pc_plus4 = PC + 4, modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-016 SHALL load PC with {branch_target[31:2],2'b00} when pc_src=1, ignoring branch_target[1:0].
REQ-017 SHALL, when pc_src=0 and stall=0, load PC with pc_plus4.
REQ-018 SHALL, when pc_src=0 and stall=1, hold PC.
REQ-019 SHALL give pc_src priority over stall for the PC update.
REQ-020 SHALL, when flush=1, load if_id_instr=32'h00000000 (nop), if_id_pc4=pc_plus4 and if_id_valid=0, regardless of stall.
REQ-021 SHALL, when flush=0 and stall=0, load if_id_instr=imem_instr, if_id_pc4=pc_plus4 and if_id_valid=1.
REQ-022 SHALL, when flush=0 and stall=1, hold all IF/ID outputs unchanged.
REQ-023 SHALL present the instruction fetched at PC=X on if_id_instr exactly one cycle after imem_addr=X while unstalled.

Reset
REQ-024 SHALL, on a clk edge with rst=1, set PC=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0 and fetch_count=0.
REQ-025 SHALL give rst priority over stall, flush and pc_src, including when rst asserts mid-stall or mid-redirect.
REQ-026 SHALL make imem_addr equal RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with macro FETCH_PERF_CNT_EN defined, implement a 32-bit fetch_count register that increments by 1 on each REQ-021 load, wraps at 2^32, and is unaffected by stall cycles and flush cycles.
REQ-028 SHALL, without FETCH_PERF_CNT_EN, omit the fetch_count port and its register entirely, with all other behaviour unchanged.

Verification
REQ-029 SHALL cover sequential fetch: reset with RESET_PC=0, release, no stall/flush -> imem_addr 0,4,8,12 on successive cycles; if_id_pc4 4,8,12 one cycle later; if_id_valid=1.
REQ-030 SHALL cover stall: stall=1 for 2 cycles while imem_addr=8 -> imem_addr stays 8 and if_id_instr/if_id_pc4=8 hold; resume -> imem_addr=12.
REQ-031 SHALL cover redirect: pc_src=1, flush=1, branch_target=32'h43 while PC=32'h10 -> next imem_addr=32'h40, if_id_instr=0, if_id_valid=0, if_id_pc4=32'h14.
REQ-032 SHALL cover simultaneous events: stall=1, flush=1, pc_src=1, target=32'h80 -> PC=32'h80 and IF/ID holds a bubble; if rst=1 in the same cycle -> PC=RESET_PC and all outputs 0.
REQ-033 SHALL cover wrap-around: RESET_PC=32'hFFFFFFFC -> second fetch address is 32'h00000000 and if_id_pc4=0.
REQ-034 SHALL cover the counter with FETCH_PERF_CNT_EN: 5 unstalled loads, 2 stall cycles and 1 flush -> fetch_count=5; rst -> 0.
